stream_uart_tx: RTL
===================

STREAM_UART_TX -- requirements
Module: stream_uart_tx

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 868, SHALL set the clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_canPeek  input  1  SHALL indicate that in_peek holds a valid byte.
REQ-006 in_peek  input  8  SHALL be the byte at the head of the upstream stream.
REQ-007 in_consume_en  output  1  SHALL pop the head byte on the rising edge where it is high.
REQ-008 uart_txd  output  1  SHALL be the serial line, idle high.
REQ-009 busy  output  1  SHALL be high whenever a frame is in progress.
REQ-010 bytes_sent  output  32  SHALL count completed frames.

Function
REQ-011 in_consume_en SHALL be combinational and SHALL equal (ready state) AND in_canPeek AND NOT reset; it SHALL never assert while in_canPeek is low.
REQ-012 Ready state SHALL be IDLE, or the final cycle of the last STOP bit.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; the state, bit-cycle counter, bit index and shift register SHALL be registered.
REQ-014 On a consume edge, in_peek SHALL be latched into the shift register, and the FSM SHALL enter START with the cycle counter loaded to CYCLES_PER_BIT-1.
REQ-015 uart_txd SHALL be driven from a register: 1 in IDLE/STOP, 0 in START, and shift[0] in DATA.
REQ-016 uart_txd SHALL fall on the cycle after the consume edge (one-cycle latency).
REQ-017 Each bit SHALL last exactly CYCLES_PER_BIT cycles; on a counter of 0 the counter SHALL reload and the FSM SHALL advance.
REQ-018 DATA SHALL send 8 bits LSB first; after bit 7, the FSM SHALL enter STOP.
REQ-019 STOP SHALL last STOP_BITS*CYCLES_PER_BIT cycles.
REQ-020 At the end of STOP, if in_canPeek is high, the next byte SHALL be consumed and START entered with no idle gap; otherwise the FSM SHALL enter IDLE.
REQ-021 The frame period SHALL be (9+STOP_BITS)*CYCLES_PER_BIT cycles; back-to-back throughput SHALL therefore be one byte per frame period.
REQ-022 bytes_sent SHALL increment by 1 on the last cycle of STOP and SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 busy SHALL be low only in IDLE.
REQ-024 Changes to in_peek or in_canPeek mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-025 While reset is high, the FSM SHALL be in IDLE and uart_txd SHALL be 1.
REQ-026 While reset is high, busy SHALL be 0, bytes_sent SHALL be 0, counters SHALL be 0, and in_consume_en SHALL be 0.
REQ-027 A reset mid-frame SHALL abort the frame; the line SHALL return high on the next edge and the aborted byte SHALL NOT be re-consumed or counted.
REQ-028 The first consume after reset release SHALL occur no earlier than the first cycle with reset low.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (2 bits) and the default CYCLES_PER_BIT constant.
REQ-030 The bit-period counter SHALL be one sub-module, uart_baud_tick (load, tick output); everything else SHALL be inline.

Verification (CYCLES_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-031 Single byte 0xA5 offered at cycle 10 -> consume at 10; txd pattern from cycle 11 = 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; busy high for cycles 11..50; bytes_sent=1 at cycle 51.
REQ-032 Three bytes 0x00, 0xFF, 0x55 continuously available -> consumes at cycles t, t+40, t+80; txd never idles between frames; bytes_sent=3.
REQ-033 in_canPeek low throughout -> in_consume_en never asserts; txd stays 1; busy stays 0.
REQ-034 STOP_BITS=2, byte 0x0F -> frame is 44 cycles with an 8-cycle high stop; next consume not before cycle t+44.
REQ-035 Reset asserted at frame cycle 15 -> txd=1 on the next edge; bytes_sent=0; the next byte is consumed on the first non-reset cycle with in_canPeek high.
REQ-036 bytes_sent forced to 0xFFFFFFFF via a bench backdoor, one frame sent -> bytes_sent=0.

Source files
------------

// File: rtl/stream_uart_tx_pkg.sv
// Shared types and defaults for the byte-stream UART transmitter.
package stream_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CYCLES_PER_BIT = 868;
  localparam int DEFAULT_STOP_BITS      = 1;

  function automatic int frame_cycles(input int cycles_per_bit, input int stop_bits);
    return (9 + stop_bits) * cycles_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: tick marks the final cycle of each bit while running.
module uart_baud_tick
  import stream_uart_tx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CYCLES_PER_BIT - 1);

  logic [15:0] count_reg;

  assign tick = run && (count_reg == 16'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= RELOAD;
    end else if (run) begin
      count_reg <= count_reg - 16'd1;
    end
  end

endmodule

// File: rtl/stream_uart_tx.sv
// Pulls bytes from a peek/consume stream and serialises them as 8N1/8N2 UART frames.
module stream_uart_tx
  import stream_uart_tx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int STOP_BITS      = DEFAULT_STOP_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_canPeek,
  input  logic [7:0]  in_peek,
  output logic        in_consume_en,
  output logic        uart_txd,
  output logic        busy,
  output logic [31:0] bytes_sent
);

  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  tx_state_t   state_reg, state_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic [31:0] sent_reg;

  logic tick;
  logic run;
  logic last_stop;
  logic ready;
  logic consume;

  assign run       = (state_reg != ST_IDLE);
  assign last_stop = (state_reg == ST_STOP) && tick && (bit_idx_reg == LAST_STOP_IDX);
  assign ready     = (state_reg == ST_IDLE) || last_stop;
  assign consume   = ready && in_canPeek && !reset;

  uart_baud_tick #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .load  (consume),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    txd_next     = 1'b1;

    case (state_reg)
      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next   = ST_STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (last_stop) begin
            state_next = ST_IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      default: begin
      end
    endcase

    // A consume overrides the end-of-stop transition so frames run back to back.
    if (consume) begin
      state_next   = ST_START;
      shift_next   = in_peek;
      bit_idx_next = '0;
    end

    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
      sent_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
      if (last_stop) begin
        sent_reg <= sent_reg + 32'd1;
      end
    end
  end

  assign in_consume_en = consume;
  assign uart_txd      = txd_reg;
  assign busy          = run;
  assign bytes_sent    = sent_reg;

endmodule
